// File: rtl/bw_io_impctl_pkg.sv
// Shared definitions for the impedance-control serial code path:
// frame state encoding, framing bit values and the default code width.
package bw_io_impctl_pkg;

    localparam int   IMPCTL_CODE_W    = 8;
    localparam logic IMPCTL_START_BIT = 1'b1;
    localparam logic IMPCTL_STOP_BIT  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } impctl_state_e;

endpackage

// File: rtl/bw_io_impctl_sclk_edge.sv
// Registers the generator's sclk and produces a one-cycle strobe on its
// rising edge; a held-high sclk yields exactly one strobe.
module bw_io_impctl_sclk_edge (
    input  logic l2clk,
    input  logic global_reset_n,
    input  logic sclk,
    output logic stb
);

    logic sclk_d;

    always_ff @(posedge l2clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sclk;
        end
    end

    // Combinational so the sample lands in the first cycle sclk reads high.
    assign stb = sclk & ~sclk_d;

endmodule

// File: rtl/bw_io_impctl_sclk_deser.sv
// Frames the serial impedance code (start, LSB-first data, even parity,
// stop) on sclk strobes and holds the last good code for the pad logic.
module bw_io_impctl_sclk_deser
    import bw_io_impctl_pkg::*;
#(
    parameter int CODE_W = IMPCTL_CODE_W
) (
    input  logic              l2clk,
    input  logic              global_reset_n,
    input  logic              sclk,
    input  logic              sdata,
    input  logic              code_ack,
    output logic [CODE_W-1:0] code_out,
    output logic              code_vld,
    output logic              busy,
    output logic              frame_err,
    output logic              ovr,
    output impctl_state_e     fsm_state
);

    localparam int                CNT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CODE_W - 1);

    logic              stb;
    impctl_state_e     state;
    logic [CNT_W-1:0]  bitcnt;
    logic [CODE_W-1:0] shreg;
    logic              par_ok;

    bw_io_impctl_sclk_edge u_sclk_edge (
        .l2clk          (l2clk),
        .global_reset_n (global_reset_n),
        .sclk           (sclk),
        .stb            (stb)
    );

    assign fsm_state = state;

    // Handshake: code_vld stays high until a cycle with code_vld & code_ack;
    // that cycle consumes code_out, and a good frame finishing in the same
    // cycle reloads it so code_vld remains high with the new code.
    always_ff @(posedge l2clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state     <= ST_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par_ok    <= 1'b0;
            code_out  <= '0;
            code_vld  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (code_vld && code_ack) begin
                code_vld <= 1'b0;
            end

            if (stb) begin
                case (state)
                    ST_IDLE: begin
                        if (sdata == IMPCTL_START_BIT) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                            busy   <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg[bitcnt] <= sdata;
                        if (bitcnt == LAST) begin
                            state <= ST_PAR;
                        end else begin
                            bitcnt <= bitcnt + CNT_W'(1);
                        end
                    end
                    ST_PAR: begin
                        par_ok <= ((^shreg) ^ sdata) == 1'b0;
                        state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (sdata == IMPCTL_STOP_BIT && par_ok) begin
                            if (!code_vld || code_ack) begin
                                code_out <= shreg;
                                code_vld <= 1'b1;
                            end else begin
                                // Holding register still owned by the consumer.
                                ovr <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bw_io_impctl_sclk_deser.sv
// Directed bench for the impctl serial code deserializer: a table of frames
// with hand-computed results plus sequences for held sclk and mid-frame reset.
module tb_bw_io_impctl_sclk_deser;
    import bw_io_impctl_pkg::*;

    logic          l2clk = 1'b0;
    logic          global_reset_n = 1'b0;
    logic          sclk = 1'b0;
    logic          sdata = 1'b0;
    logic          code_ack = 1'b0;
    logic [7:0]    code_out;
    logic          code_vld;
    logic          busy;
    logic          frame_err;
    logic          ovr;
    impctl_state_e fsm_state;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       ack_stop;
        logic       ack_after;
        logic [7:0] exp_code;
        logic       exp_vld;
        logic       exp_err;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[7];

    always #5 l2clk = ~l2clk;

    bw_io_impctl_sclk_deser #(.CODE_W(8)) dut (
        .l2clk          (l2clk),
        .global_reset_n (global_reset_n),
        .sclk           (sclk),
        .sdata          (sdata),
        .code_ack       (code_ack),
        .code_out       (code_out),
        .code_vld       (code_vld),
        .busy           (busy),
        .frame_err      (frame_err),
        .ovr            (ovr),
        .fsm_state      (fsm_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One sclk high cycle carrying bit b, followed by idle low cycles.
    task automatic pulse(input logic b, input int idle);
        @(negedge l2clk);
        sclk  = 1'b1;
        sdata = b;
        @(negedge l2clk);
        sclk  = 1'b0;
        repeat (idle) @(negedge l2clk);
    endtask

    task automatic send_frame(input vec_t v, input string tag);
        pulse(IMPCTL_START_BIT, 2);
        for (int i = 0; i < 8; i++) pulse(v.data[i], 2);
        pulse(v.par, 2);
        @(negedge l2clk);
        sclk     = 1'b1;
        sdata    = v.stop;
        code_ack = v.ack_stop;
        @(negedge l2clk);
        sclk     = 1'b0;
        code_ack = 1'b0;
        check({tag, "_code"}, 32'(code_out), 32'(v.exp_code));
        check({tag, "_vld"}, 32'(code_vld), 32'(v.exp_vld));
        check({tag, "_err"}, 32'(frame_err), 32'(v.exp_err));
        check({tag, "_ovr"}, 32'(ovr), 32'(v.exp_ovr));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
        code_ack = v.ack_after;
        @(negedge l2clk);
        code_ack = 1'b0;
        check({tag, "_err_pulse"}, 32'(frame_err), 32'd0);
        if (v.ack_after) check({tag, "_vld_acked"}, 32'(code_vld), 32'd0);
        @(negedge l2clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          data   par   stop  ackS  ackA  code   vld   err   ovr
        vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge l2clk);
        check("rst_code", 32'(code_out), 32'd0);
        check("rst_vld", 32'(code_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        global_reset_n = 1'b1;
        repeat (2) @(negedge l2clk);

        for (int i = 0; i < 7; i++) send_frame(vecs[i], $sformatf("v%0d", i));

        // sclk held high: a single strobe takes the start bit only.
        @(negedge l2clk);
        sclk  = 1'b1;
        sdata = 1'b1;
        @(negedge l2clk);
        check("hold_state_first", 32'(fsm_state), 32'(ST_DATA));
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_bitcnt_first", 32'(dut.bitcnt), 32'd0);
        repeat (9) @(negedge l2clk);
        check("hold_state_last", 32'(fsm_state), 32'(ST_DATA));
        check("hold_bitcnt_last", 32'(dut.bitcnt), 32'd0);
        sclk = 1'b0;
        repeat (2) @(negedge l2clk);

        // Four data bits of 0xFF, then reset mid-frame.
        for (int i = 0; i < 4; i++) pulse(1'b1, 2);
        check("mid_bitcnt", 32'(dut.bitcnt), 32'd4);
        check("mid_ovr", 32'(ovr), 32'd1);
        @(negedge l2clk);
        global_reset_n = 1'b0;
        #1;
        check("mrst_code", 32'(code_out), 32'd0);
        check("mrst_vld", 32'(code_vld), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_err", 32'(frame_err), 32'd0);
        check("mrst_ovr", 32'(ovr), 32'd0);
        check("mrst_state", 32'(fsm_state), 32'(ST_IDLE));
        @(negedge l2clk);
        global_reset_n = 1'b1;
        repeat (2) @(negedge l2clk);
        send_frame('{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0}, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bw_io_impctl_sclk_deser.md
# bw_io_impctl_sclk_deser

Receive-side companion to the impedance-control slow-clock generator. It runs in the `l2clk` domain and treats the generator's registered `sclk` as a sample strobe. On each strobe it samples a serial impedance-code line, frames and checks each word, and presents the parallel code to the pad-driver update logic through a valid/ack handshake. It sits between the impctl serial code bus and the per-pad code holding registers.

## Interface
Parameters:
- `CODE_W`, 8: data bits per frame.

Ports:
- `l2clk`, in, 1: sole clock. All flops are rising-edge.
- `global_reset_n`, in, 1: asynchronous, active-low reset.
- `sclk`, in, 1: slow-clock strobe from the generator, synchronous to `l2clk`. It is nominally high 1 cycle in 4.
- `sdata`, in, 1: serial code line. It is stable whenever `sclk` is high.
- `code_ack`, in, 1: consumer accepts `code_out`.
- `code_out`, out, CODE_W: last good received code.
- `code_vld`, out, 1: `code_out` is holding an unacknowledged code.
- `busy`, out, 1: a frame is in progress (FSM not IDLE).
- `frame_err`, out, 1: single-cycle pulse on a parity or stop error.
- `ovr`, out, 1: sticky overrun flag. It is cleared only by reset.

## Operation
- Strobe: `stb = sclk & ~sclk_d`, where `sclk_d` is `sclk` registered. If `sclk` is held high, it yields exactly one strobe. `sdata` is sampled only on `stb`.
- Frame, serialized LSB first:
  - start bit = 1
  - CODE_W data bits
  - even parity over the data bits (parity bit makes the total count of ones even)
  - stop bit = 0
- FSM states: IDLE, DATA, PAR, STOP.
  - IDLE: on `stb` with `sdata`=1, go to DATA and clear `bitcnt`. On `stb` with `sdata`=0, stay in IDLE (line idle).
  - DATA: on `stb`, shift `sdata` into `shreg[bitcnt]` and increment `bitcnt`. When `bitcnt`==CODE_W-1 at the strobe, go to PAR.
  - PAR: on `stb`, latch `par_ok = (^shreg ^ sdata)==0` and go to STOP.
  - STOP: on `stb`, go to IDLE and evaluate the frame:
    - Good frame: `sdata`==0 and `par_ok`.
    - Bad frame: pulse `frame_err` for 1 cycle. `code_out` and `code_vld` are unchanged.
- Good-frame delivery:
  - If `code_vld`=0, or `code_ack`=1 in the same cycle: load `code_out <= shreg` and set `code_vld`=1.
  - Otherwise (holding is full): drop the new code, set `ovr`=1, and keep the old `code_out`.
- Handshake: the consumer accepts on a cycle with `code_vld & code_ack`. That cycle clears `code_vld` unless a good frame loads in the same cycle, in which case `code_vld` stays 1 with the new data. `code_ack` while `code_vld`=0 is ignored.
- Width rules:
  - `bitcnt` is $clog2(CODE_W) bits wide and never wraps past CODE_W-1.
  - `shreg` is CODE_W bits. Bit 0 is the first data bit received.
- Reset behaviour:
  - Reset at any point, including mid-frame, forces IDLE.
  - Clears `shreg`, `bitcnt`, `sclk_d`, and `par_ok`.
  - The partial frame is discarded and no error is flagged.

## Timing
- Reset values: `code_out`=0, `code_vld`=0, `busy`=0, `frame_err`=0, `ovr`=0.
- Strobe timing: `stb` is asserted in the same cycle `sclk` first reads high. There is no added latency before the sample.
- Output latency: `code_vld`, `frame_err`, and `ovr` update on the clock edge that ends the STOP-strobe cycle. They are visible 1 cycle after the stop-bit strobe.
- Frame length: CODE_W+3 strobes. At the nominal 1-in-4 `sclk`, that is 44 `l2clk` cycles for CODE_W=8.
- `busy` is registered. It rises 1 cycle after the start strobe and falls 1 cycle after the stop strobe.
- Back-to-back frames: a start bit on the strobe immediately after the stop strobe is accepted. No idle strobe is required.

## Structure
- Shared package `bw_io_impctl_pkg`:
  - FSM state enum (IDLE/DATA/PAR/STOP)
  - `IMPCTL_START_BIT`=1 and `IMPCTL_STOP_BIT`=0
  - default CODE_W
- One natural sub-module: `bw_io_impctl_sclk_edge`, the `sclk` register plus rising-edge strobe. It is reusable by the other `sclk` consumers.
- The rest is a single flat module: FSM, shift register, output holding register.

## Test plan
- Basic receive: CODE_W=8, nominal 1-in-4 `sclk`, send 0xA5 (parity 0, stop 0). Required: `code_out`=0xA5 and `code_vld`=1 one cycle after the stop strobe. `code_ack` then clears `code_vld` next cycle.
- Parity error: send 0x3C with parity=1. Required: a 1-cycle `frame_err` pulse, `code_vld` stays 0, `code_out` stays 0.
- Stop error: send 0x01 with parity=1 and stop=1. Required: `frame_err` pulse and FSM back to IDLE. The next good frame 0x02 is received correctly.
- Overrun: receive 0x11 and hold `code_ack`=0, then receive 0x22. Required: `ovr`=1 and `code_out` stays 0x11. A third frame 0x33 whose stop strobe coincides with `code_ack`=1 loads 0x33 with `code_vld` remaining 1.
- `sclk` held high for 10 cycles with `sdata`=1. Required: exactly one strobe, FSM goes to DATA, `bitcnt`=0.
- Reset mid-frame: assert `global_reset_n`=0 after 4 data bits of 0xFF. Required: all outputs return to reset values immediately. A following full frame 0x5A is received correctly.
